// File: rtl/tx_framer_if.sv
`default_nettype none
// ============================================================================
// Module      : tx_framer_if
// Description : Sample-stream input, DAC strobe/data output and frame status
//               signals of the transmit framer, bundled for port connection.
// Revision    : 1.0 - initial release
// ============================================================================
interface tx_framer_if;
  // Upstream sample stream: {Q[31:16], I[15:0]}
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_last;
  logic        s_ready;
  // DAC side
  logic        dac_valid;
  logic [31:0] dac_data;
  // Frame status
  logic        busy;
  logic        underrun;
  logic        done;

  // Source of samples and strobes (testbench / upstream + DAC pacing)
  modport master (
    output s_valid, s_data, s_last, dac_valid,
    input  s_ready, dac_data, busy, underrun, done
  );

  // The framer itself
  modport slave (
    input  s_valid, s_data, s_last, dac_valid,
    output s_ready, dac_data, busy, underrun, done
  );
endinterface
`default_nettype wire

// File: rtl/tx_framer.sv
`default_nettype none
// ============================================================================
// Module      : tx_framer
// Description : Transmit framer. Prepends a repeated BPSK preamble to a frame
//               of packed IQ samples, appends a zero guard interval and
//               presents one sample per DAC strobe on a registered output.
// Revision    : 1.0 - initial release
// ============================================================================
module tx_framer #(
  parameter int                       PREAMBLE_LEN  = 16,
  parameter int                       PREAMBLE_REPS = 10,
  parameter logic [PREAMBLE_LEN-1:0]  PATTERN       = 16'hB38F,
  parameter logic signed [15:0]       AMP           = 16'sd8192,
  parameter int                       GUARD_LEN     = 16
) (
  input  logic       clk,
  input  logic       reset,
  tx_framer_if.slave bus
);

  // Counter widths sized to hold the full count so the "last" compare is exact
  localparam int KW = $clog2(PREAMBLE_LEN + 1);
  localparam int RW = $clog2(PREAMBLE_REPS + 1);
  localparam int GW = $clog2(GUARD_LEN + 1);

  localparam logic [KW-1:0] c_k_last     = KW'(PREAMBLE_LEN - 1);
  localparam logic [RW-1:0] c_rep_last   = RW'(PREAMBLE_REPS - 1);
  localparam logic [GW-1:0] c_guard_last = GW'(GUARD_LEN - 1);
  localparam logic [15:0]   c_amp_pos    = AMP;
  localparam logic [15:0]   c_amp_neg    = 16'(-AMP);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_PAYLOAD  = 2'd2,
    ST_GUARD    = 2'd3
  } state_t;

  state_t            r_state;
  logic [KW-1:0]     r_k;
  logic [RW-1:0]     r_rep;
  logic [GW-1:0]     r_guard;
  logic [31:0]       r_dac_data;
  logic              r_busy;
  logic              r_underrun;
  logic              r_done;

  state_t            w_state_nxt;
  logic [KW-1:0]     w_k_nxt;
  logic [RW-1:0]     w_rep_nxt;
  logic [GW-1:0]     w_guard_nxt;
  logic [31:0]       w_data_nxt;
  logic              w_underrun_nxt;
  logic              w_done_nxt;
  logic              w_tick;
  logic [KW-1:0]     w_k_emit;
  logic [PREAMBLE_LEN-1:0] w_pat_shift;
  logic              w_pat_bit;
  logic [31:0]       w_pre_sample;

  assign w_tick = bus.dac_valid;

  // The start tick in IDLE emits sample 0; in PREAMBLE the counter names the
  // sample. Shifting the pattern left brings the selected bit to the MSB.
  assign w_k_emit     = (r_state == ST_IDLE) ? '0 : r_k;
  assign w_pat_shift  = PATTERN << w_k_emit;
  assign w_pat_bit    = w_pat_shift[PREAMBLE_LEN-1];
  assign w_pre_sample = {16'h0000, (w_pat_bit ? c_amp_pos : c_amp_neg)};

  // Upstream may only hand over a sample on a payload tick
  assign bus.s_ready  = (r_state == ST_PAYLOAD) && bus.dac_valid;

  assign bus.dac_data = r_dac_data;
  assign bus.busy     = r_busy;
  assign bus.underrun = r_underrun;
  assign bus.done     = r_done;

  // Next-state and next-output decode; nothing moves on non-tick cycles
  always_comb begin
    w_state_nxt    = r_state;
    w_k_nxt        = r_k;
    w_rep_nxt      = r_rep;
    w_guard_nxt    = r_guard;
    w_data_nxt     = r_dac_data;
    w_underrun_nxt = 1'b0;
    w_done_nxt     = 1'b0;

    if (w_tick) begin
      unique case (r_state)
        ST_IDLE: begin
          w_data_nxt = '0;
          // A waiting sample starts the frame but is not consumed yet
          if (bus.s_valid) begin
            w_data_nxt  = w_pre_sample;
            w_state_nxt = ST_PREAMBLE;
            w_k_nxt     = KW'(1);
            w_rep_nxt   = '0;
          end
        end

        ST_PREAMBLE: begin
          w_data_nxt = w_pre_sample;
          if (r_k == c_k_last) begin
            w_k_nxt = '0;
            if (r_rep == c_rep_last) begin
              w_rep_nxt   = '0;
              w_state_nxt = ST_PAYLOAD;
            end else begin
              w_rep_nxt = r_rep + RW'(1);
            end
          end else begin
            w_k_nxt = r_k + KW'(1);
          end
        end

        ST_PAYLOAD: begin
          if (bus.s_valid) begin
            w_data_nxt = bus.s_data;
            if (bus.s_last) begin
              w_state_nxt = ST_GUARD;
              w_guard_nxt = '0;
            end
          end else begin
            // Starved tick: keep the DAC fed with silence and flag it
            w_data_nxt     = '0;
            w_underrun_nxt = 1'b1;
          end
        end

        ST_GUARD: begin
          w_data_nxt = '0;
          if (r_guard == c_guard_last) begin
            w_guard_nxt = '0;
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_guard_nxt = r_guard + GW'(1);
          end
        end

        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Counters, output sample and status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_k        <= '0;
      r_rep      <= '0;
      r_guard    <= '0;
      r_dac_data <= '0;
      r_busy     <= 1'b0;
      r_underrun <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_k        <= w_k_nxt;
      r_rep      <= w_rep_nxt;
      r_guard    <= w_guard_nxt;
      r_dac_data <= w_data_nxt;
      r_busy     <= (w_state_nxt != ST_IDLE);
      r_underrun <= w_underrun_nxt;
      r_done     <= w_done_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tx_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_tx_framer
// Description : Self-checking bench for tx_framer. A frame-level reference
//               model lists the expected DAC sample of every tick of a frame.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_tx_framer;

  localparam int          PL   = 16;
  localparam int          PR   = 10;
  localparam int          GL   = 16;
  localparam int          PRE  = PL * PR;
  localparam logic [15:0] PAT  = 16'hB38F;
  localparam logic [15:0] AMPV = 16'h2000;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  tx_framer_if bus();

  tx_framer #(
    .PREAMBLE_LEN  (PL),
    .PREAMBLE_REPS (PR),
    .PATTERN       (PAT),
    .AMP           (16'sd8192),
    .GUARD_LEN     (GL)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_und_seen = 0;

  // Expected output per tick of the current frame
  logic [31:0] e_d[$];
  bit          e_u[$];
  // Input-side plan: one entry per payload tick (gap entries have valid=0)
  bit          p_v[$];
  logic [31:0] p_d[$];
  bit          p_l[$];

  int          m_plen;
  int          m_idx;
  bit          m_busy;
  bit          m_und;
  bit          m_done;
  bit          m_frame_done;
  logic [31:0] m_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] pre_sample(input int k);
    logic [15:0] pat;
    pat = PAT;
    return pat[PL-1-k] ? {16'h0000, AMPV} : {16'h0000, 16'h0000 - AMPV};
  endfunction

  task automatic begin_frame();
    e_d.delete(); e_u.delete();
    p_v.delete(); p_d.delete(); p_l.delete();
    for (int r = 0; r < PR; r++)
      for (int k = 0; k < PL; k++) begin
        e_d.push_back(pre_sample(k));
        e_u.push_back(1'b0);
      end
    m_frame_done = 1'b0;
  endtask

  task automatic add_sample(input logic [31:0] d, input bit last);
    p_v.push_back(1'b1); p_d.push_back(d); p_l.push_back(last);
    e_d.push_back(d);    e_u.push_back(1'b0);
  endtask

  task automatic add_gap();
    p_v.push_back(1'b0); p_d.push_back(32'h0); p_l.push_back(1'b0);
    e_d.push_back(32'h0); e_u.push_back(1'b1);
  endtask

  task automatic end_frame();
    for (int g = 0; g < GL; g++) begin
      e_d.push_back(32'h0);
      e_u.push_back(1'b0);
    end
    m_plen = p_v.size();
  endtask

  task automatic random_frame();
    int n;
    n = $urandom_range(1, 6);
    begin_frame();
    for (int i = 0; i < n; i++) begin
      if (i > 0) repeat ($urandom_range(0, 2)) add_gap();
      add_sample($urandom, i == n - 1);
    end
    end_frame();
  endtask

  // One clock cycle: drive, check s_ready, advance the model, check outputs
  task automatic step(input bit dv);
    bit sv;
    bit rdy_e;
    bus.dac_valid = dv;
    if (p_v.size() > 0) begin
      bus.s_valid = p_v[0];
      bus.s_data  = p_d[0];
      bus.s_last  = p_l[0];
    end else begin
      bus.s_valid = 1'b0;
      bus.s_data  = 32'h0;
      bus.s_last  = 1'b0;
    end
    sv    = bus.s_valid;
    rdy_e = dv && m_busy && (m_idx >= PRE) && (m_idx < PRE + m_plen);
    #1;
    check("s_ready", {31'b0, bus.s_ready}, {31'b0, rdy_e});
    @(posedge clk);
    #1;
    m_und  = 1'b0;
    m_done = 1'b0;
    if (dv) begin
      if (!m_busy && sv) begin
        m_busy = 1'b1;
        m_idx  = 0;
      end
      if (m_busy) begin
        m_data = e_d[m_idx];
        m_und  = e_u[m_idx];
        if (rdy_e) begin
          void'(p_v.pop_front()); void'(p_d.pop_front()); void'(p_l.pop_front());
        end
        m_idx++;
        if (m_idx == e_d.size()) begin
          m_busy       = 1'b0;
          m_done       = 1'b1;
          m_frame_done = 1'b1;
        end
      end else begin
        m_data = 32'h0;
      end
    end
    if (bus.underrun) n_und_seen++;
    check("dac_data", bus.dac_data, m_data);
    check("busy",     {31'b0, bus.busy},     {31'b0, m_busy});
    check("underrun", {31'b0, bus.underrun}, {31'b0, m_und});
    check("done",     {31'b0, bus.done},     {31'b0, m_done});
  endtask

  // mode 0: strobe every cycle, 1: every 4th cycle, 2: random sparse
  task automatic run_frame(input int mode, output int steps);
    int  cyc;
    bit  dv;
    cyc = 0;
    while (!m_frame_done && cyc < 4000) begin
      case (mode)
        0:       dv = 1'b1;
        1:       dv = (cyc % 4 == 0);
        default: dv = ($urandom_range(0, 2) == 0);
      endcase
      step(dv);
      cyc++;
    end
    if (!m_frame_done) check("frame_timeout", 32'd0, 32'd1);
    steps = cyc;
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_idx = 0; m_data = 32'h0;
    m_und  = 1'b0; m_done = 1'b0;
    p_v.delete(); p_d.delete(); p_l.delete();
  endtask

  initial begin
    int steps;
    bus.dac_valid = 1'b0;
    bus.s_valid   = 1'b0;
    bus.s_data    = 32'h0;
    bus.s_last    = 1'b0;
    model_reset();
    m_plen = 0;
    m_frame_done = 1'b0;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_dac_data", bus.dac_data, 32'h0);
    check("rst_busy",     {31'b0, bus.busy},     32'h0);
    check("rst_underrun", {31'b0, bus.underrun}, 32'h0);
    check("rst_done",     {31'b0, bus.done},     32'h0);
    check("rst_s_ready",  {31'b0, bus.s_ready},  32'h0);

    // Idle with continuous strobe and no input
    repeat (50) step(1'b1);

    // Full frame, strobe every cycle
    begin_frame();
    add_sample(32'h11112222, 1'b0);
    add_sample(32'h33334444, 1'b0);
    add_sample(32'h55556666, 1'b1);
    end_frame();
    run_frame(0, steps);
    check("full_frame_len", steps, 32'd179);

    // Same frame, strobe every 4th cycle
    begin_frame();
    add_sample(32'h11112222, 1'b0);
    add_sample(32'h33334444, 1'b0);
    add_sample(32'h55556666, 1'b1);
    end_frame();
    run_frame(1, steps);
    check("sparse_frame_len", steps, 32'd713);

    // Two starved ticks mid-payload
    n_und_seen = 0;
    begin_frame();
    add_sample(32'hA0A0A0A0, 1'b0);
    add_gap();
    add_gap();
    add_sample(32'hB1B1B1B1, 1'b0);
    add_sample(32'hC2C2C2C2, 1'b1);
    end_frame();
    run_frame(0, steps);
    check("underrun_frame_len", steps, 32'd181);
    check("underrun_pulses", n_und_seen, 32'd2);

    // Reset in the middle of the preamble
    begin_frame();
    add_sample(32'hDEADBEEF, 1'b1);
    end_frame();
    repeat (40) step(1'b1);
    #2 reset = 1'b1;
    #1;
    check("midrst_dac_data", bus.dac_data, 32'h0);
    check("midrst_busy",     {31'b0, bus.busy}, 32'h0);
    bus.dac_valid = 1'b0;
    bus.s_valid   = 1'b0;
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    begin_frame();
    add_sample(32'h0BADF00D, 1'b0);
    add_sample(32'hFEEDC0DE, 1'b1);
    end_frame();
    step(1'b1);
    check("restart_sample0", bus.dac_data, 32'h00002000);
    run_frame(0, steps);

    // Randomized frames, strobes and idle gaps (gap 0 = back-to-back)
    for (int f = 0; f < 6; f++) begin
      repeat ($urandom_range(0, 5)) step($urandom_range(0, 1) == 1);
      random_frame();
      run_frame($urandom_range(0, 2), steps);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
